axil_sample_reader: RTL
=======================

// Module: axil_sample_reader
// PURPOSE
//  AXI-Lite read master that fetches consecutive 32-bit audio words from an AXI-Lite sample memory.
//  Buffers the words in a small FIFO and presents them as a valid/ready sample stream to the audio output path.
//  Read-only: no AW/W/B channels. One read transaction outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH  32  AXI-Lite address width
//  DATA_WIDTH  32  AXI-Lite data / sample width
//  ADDR_INCR   1   araddr step per word (sample memory is word-addressed)
//  FIFO_DEPTH  4   sample FIFO entries, power of two, >=2
//  LEN_WIDTH   24  width of length_words
// PORTS
//  aclk            in   1           clock
//  aresetn         in   1           synchronous active-low reset
//  start           in   1           1-cycle pulse: begin playback (ignored while busy)
//  stop            in   1           1-cycle pulse: end playback after the in-flight transaction
//  base_addr       in   ADDR_WIDTH  first word address, sampled on accepted start
//  length_words    in   LEN_WIDTH   words to fetch, sampled on accepted start
//  busy            out  1           high from accepted start until return to IDLE
//  done            out  1           1-cycle pulse on return to IDLE
//  err             out  1           sticky: any rresp != 2'b00; cleared on accepted start
//  m_axil_araddr   out  ADDR_WIDTH  read address
//  m_axil_arprot   out  3           constant 3'b000
//  m_axil_arvalid  out  1           read address valid
//  m_axil_arready  in   1           read address ready
//  m_axil_rdata    in   DATA_WIDTH  read data
//  m_axil_rresp    in   2           read response
//  m_axil_rvalid   in   1           read data valid
//  m_axil_rready   out  1           read data ready
//  sample_data     out  DATA_WIDTH  FIFO head word
//  sample_valid    out  1           FIFO non-empty
//  sample_ready    in   1           consumer accepts sample_data
// BEHAVIOUR
//  Reset: all outputs 0, FIFO flushed, FSM IDLE, address/count regs 0. Reset mid-transaction abandons it silently.
//  FSM: IDLE -> (start & length_words!=0) -> ADDR. IDLE -> (start & length_words==0) -> IDLE, with done pulsed next cycle and no bus traffic.
//   ADDR: enter only if FIFO free slots >=1 (else WAIT). arvalid=1, araddr=cur_addr; araddr is held stable until arready. -> DATA on arvalid&arready.
//   WAIT: arvalid=0; -> ADDR when a slot frees.
//   DATA: rready=1 (a slot is reserved, so the FIFO never overflows). On rvalid: push rdata, OR rresp!=0 into err, cur_addr+=ADDR_INCR, remaining-=1.
//    Then: remaining==0 or stop_pending -> IDLE with done; else -> ADDR/WAIT.
//  Latency: accepted start -> arvalid at cycle+1. R handshake -> sample_valid at cycle+1 when FIFO was empty.
//  stop is latched as stop_pending. It never drops arvalid once asserted; the in-flight beat always completes and is pushed.
//  stop in IDLE is ignored. start while busy is ignored. start and stop in the same IDLE cycle: start wins, stop ignored.
//  FIFO: push and pop in the same cycle leave count unchanged. Contents persist after done until drained. An accepted start does not flush them.
//  Address arithmetic: cur_addr wraps modulo 2^ADDR_WIDTH; no error is raised.
//  Error responses do not abort playback; the data is still pushed.
// CONFIGURATION
//  AXIL_SAMPLE_READER_LOOP_EN defined:
//   when remaining reaches 0, cur_addr reloads base_addr and remaining reloads length_words, and fetching continues.
//   Only stop or reset end playback; done pulses only after stop.
//  Not defined: playback ends after length_words words; done pulses; busy drops.
// TESTING
//  base=0x10, len=4, sample_ready=1, slave arready=1, rvalid 1 cycle after AR -> araddr 0x10,0x11,0x12,0x13;
//   sample_data = mem[0x10..0x13] in order; done pulses exactly once.
//  len=8, FIFO_DEPTH=4, sample_ready=0 -> exactly 4 AR handshakes, then arvalid stays 0.
//   Raise sample_ready -> remaining 4 fetched; no sample lost or duplicated.
//  Slave holds arready=0 for 5 cycles -> arvalid stays 1 and araddr is stable throughout; transfer completes normally.
//  rresp=2'b10 on word 2 of 3 -> err=1 after that beat; all 3 samples delivered. Next start clears err.
//  start with len=0 -> done 1 cycle later; arvalid never asserted.
//   stop during DATA -> beat completes, done pulses, no further AR.
//  aresetn=0 while arvalid=1 -> all outputs 0 next cycle, FIFO empty.
//   LOOP_EN build, len=2 -> araddr base, base+1, base, base+1... until stop.

Source files
------------

// File: rtl/axil_sample_reader_if.sv
// AXI-Lite read-only channel bundle (AR + R) between the sample reader
// and the sample memory.
interface axil_sample_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_sample_reader.sv
// AXI-Lite read master streaming consecutive words into a sample FIFO.
// Optional macro AXIL_SAMPLE_READER_LOOP_EN: loop the buffer until stop.
module axil_sample_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_INCR  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   stop,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [LEN_WIDTH-1:0]   length_words,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    axil_sample_reader_if.master   m_axil,
    output logic [DATA_WIDTH-1:0]  sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_n;
    logic [LEN_WIDTH-1:0]  remaining, remaining_n;
    logic                  err_n;
    logic                  done_n;
    logic                  stop_pend, stop_pend_n;
`ifdef AXIL_SAMPLE_READER_LOOP_EN
    logic [ADDR_WIDTH-1:0] base_q, base_n;
    logic [LEN_WIDTH-1:0]  len_q, len_n;
`endif

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         fifo_cnt, fifo_cnt_n;
    logic                  push, pop;
    logic                  slot_free;
    logic                  stop_any;
    logic                  last_word;
    logic                  end_play;

    assign push       = (state == S_DATA) && m_axil.rvalid;
    assign pop        = sample_valid && sample_ready;
    assign fifo_cnt_n = fifo_cnt + CW'(push) - CW'(pop);
    // Free-slot test uses the post-update count so a slot is reserved
    // before the address phase and the read beat can never overflow.
    assign slot_free  = fifo_cnt_n < CW'(FIFO_DEPTH);
    assign stop_any   = stop || stop_pend;
    assign last_word  = (remaining == LEN_WIDTH'(1));

`ifdef AXIL_SAMPLE_READER_LOOP_EN
    assign end_play = stop_any;
`else
    assign end_play = last_word || stop_any;
`endif

    assign m_axil.araddr  = cur_addr;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = (state == S_ADDR);
    assign m_axil.rready  = (state == S_DATA);

    assign busy         = (state != S_IDLE);
    assign sample_valid = (fifo_cnt != '0);
    assign sample_data  = sample_valid ? fifo_mem[rd_ptr] : '0;

    always_comb begin
        state_n     = state;
        cur_addr_n  = cur_addr;
        remaining_n = remaining;
        err_n       = err;
        done_n      = 1'b0;
        stop_pend_n = stop_pend;
`ifdef AXIL_SAMPLE_READER_LOOP_EN
        base_n      = base_q;
        len_n       = len_q;
`endif
        if (stop && state != S_IDLE) stop_pend_n = 1'b1;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    err_n       = 1'b0;
                    stop_pend_n = 1'b0;
                    cur_addr_n  = base_addr;
                    remaining_n = length_words;
`ifdef AXIL_SAMPLE_READER_LOOP_EN
                    base_n      = base_addr;
                    len_n       = length_words;
`endif
                    if (length_words == '0) done_n = 1'b1;
                    else state_n = slot_free ? S_ADDR : S_WAIT;
                end
            end
            S_ADDR: begin
                if (m_axil.arready) state_n = S_DATA;
            end
            S_WAIT: begin
                // Nothing is in flight here, so a stop ends playback at once.
                if (stop_any) begin
                    state_n     = S_IDLE;
                    done_n      = 1'b1;
                    stop_pend_n = 1'b0;
                end else if (slot_free) begin
                    state_n = S_ADDR;
                end
            end
            S_DATA: begin
                if (m_axil.rvalid) begin
                    err_n       = err | (m_axil.rresp != 2'b00);
                    cur_addr_n  = cur_addr + ADDR_WIDTH'(ADDR_INCR);
                    remaining_n = remaining - LEN_WIDTH'(1);
`ifdef AXIL_SAMPLE_READER_LOOP_EN
                    if (last_word) begin
                        cur_addr_n  = base_q;
                        remaining_n = len_q;
                    end
`endif
                    if (end_play) begin
                        state_n     = S_IDLE;
                        done_n      = 1'b1;
                        stop_pend_n = 1'b0;
                    end else begin
                        state_n = slot_free ? S_ADDR : S_WAIT;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            stop_pend <= 1'b0;
`ifdef AXIL_SAMPLE_READER_LOOP_EN
            base_q    <= '0;
            len_q     <= '0;
`endif
        end else begin
            state     <= state_n;
            cur_addr  <= cur_addr_n;
            remaining <= remaining_n;
            err       <= err_n;
            done      <= done_n;
            stop_pend <= stop_pend_n;
`ifdef AXIL_SAMPLE_READER_LOOP_EN
            base_q    <= base_n;
            len_q     <= len_n;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            fifo_cnt <= fifo_cnt_n;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr] <= m_axil.rdata;
    end
endmodule
